// File: rtl/t05_cb_sram_sched.sv
// CODEBOOK-phase SRAM port scheduler.
// Shares one 32-bit SRAM port between 64-bit htree reads and 128-bit codepath writes.
// Each access is split into word transfers. A single pending slot buffers the write request.
module t05_cb_sram_sched #(
    parameter logic [31:0] HT_BASE = 32'h0000_0000,
    parameter logic [31:0] CB_BASE = 32'h0000_0800
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         rd_req_i,
    input  logic [6:0]   rd_index_i,
    output logic [63:0]  rd_data_o,
    output logic         rd_valid_o,
    input  logic         wr_req_i,
    input  logic [7:0]   wr_index_i,
    input  logic [127:0] wr_path_i,
    output logic         wr_done_o,
    output logic         wr_ovf_o,
    output logic         busy_o,
    output logic         sram_req_o,
    output logic         sram_we_o,
    output logic [31:0]  sram_addr_o,
    output logic [31:0]  sram_wdata_o,
    input  logic [31:0]  sram_rdata_i,
    input  logic         sram_ack_i
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

    state_e         state_q, state_d;
    logic [1:0]     word_q, word_d;
    logic [6:0]     rd_idx_q, rd_idx_d;
    logic           rsp_wr_q, rsp_wr_d;
    logic [63:0]    rd_data_q, rd_data_d;
    logic           pend_q, pend_d;
    logic [7:0]     pend_idx_q, pend_idx_d;
    logic [127:0]   pend_path_q, pend_path_d;
    logic           ovf_q, ovf_d;
    logic           pend_clr;

    logic [31:0]    ht_addr;
    logic [31:0]    cb_addr;
    logic [31:0]    path_word;

    assign ht_addr = HT_BASE + {22'd0, rd_idx_q, 3'd0} + {28'd0, word_q, 2'd0};
    assign cb_addr = CB_BASE + {20'd0, pend_idx_q, 4'd0} + {28'd0, word_q, 2'd0};

    // Path words go out most-significant first.
    always_comb begin
        path_word = pend_path_q[127:96];
        unique case (word_q)
            2'd0:    path_word = pend_path_q[127:96];
            2'd1:    path_word = pend_path_q[95:64];
            2'd2:    path_word = pend_path_q[63:32];
            2'd3:    path_word = pend_path_q[31:0];
            default: path_word = pend_path_q[127:96];
        endcase
    end

    // Transaction sequencing: arbitration in IDLE, word stepping on ack, one response cycle.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        rd_idx_d  = rd_idx_q;
        rsp_wr_d  = rsp_wr_q;
        rd_data_d = rd_data_q;
        pend_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    // A write arriving this cycle already counts as pending, so it beats a read.
                    if (pend_q || wr_req_i) begin
                        state_d  = StWr;
                        word_d   = 2'd0;
                        rsp_wr_d = 1'b1;
                    end else if (rd_req_i) begin
                        state_d  = StRd;
                        word_d   = 2'd0;
                        rd_idx_d = rd_index_i;
                        rsp_wr_d = 1'b0;
                    end
                end
            end
            StRd: begin
                if (sram_ack_i) begin
                    if (word_q == 2'd0) begin
                        rd_data_d[63:32] = sram_rdata_i;
                    end else begin
                        rd_data_d[31:0] = sram_rdata_i;
                    end
                    if (word_q == 2'd1) begin
                        state_d = StRsp;
                        word_d  = 2'd0;
                    end else begin
                        word_d = word_q + 2'd1;
                    end
                end
            end
            StWr: begin
                if (sram_ack_i) begin
                    if (word_q == 2'd3) begin
                        state_d  = StRsp;
                        word_d   = 2'd0;
                        pend_clr = 1'b1;
                    end else begin
                        word_d = word_q + 2'd1;
                    end
                end
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pending write slot: first request wins, later ones only flag overflow.
    always_comb begin
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        pend_path_d = pend_path_q;
        ovf_d       = ovf_q;
        if (wr_req_i) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_idx_d  = wr_index_i;
                pend_path_d = wr_path_i;
            end
        end
        if (pend_clr) begin
            pend_d = 1'b0;
        end
    end

    // SRAM port drive; address and data are quiet outside a transfer.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = 32'd0;
        sram_wdata_o = 32'd0;
        if (state_q == StRd) begin
            sram_req_o  = 1'b1;
            sram_addr_o = ht_addr;
        end else if (state_q == StWr) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = cb_addr;
            sram_wdata_o = path_word;
        end
    end

    assign rd_valid_o = (state_q == StRsp) && !rsp_wr_q;
    assign wr_done_o  = (state_q == StRsp) && rsp_wr_q;
    assign rd_data_o  = rd_data_q;
    assign wr_ovf_o   = ovf_q;
    assign busy_o     = (state_q != StIdle) || pend_q;

    // State and slot registers; reset abandons any partial transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_q      <= 2'd0;
            rd_idx_q    <= 7'd0;
            rsp_wr_q    <= 1'b0;
            rd_data_q   <= 64'd0;
            pend_q      <= 1'b0;
            pend_idx_q  <= 8'd0;
            pend_path_q <= 128'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            rd_idx_q    <= rd_idx_d;
            rsp_wr_q    <= rsp_wr_d;
            rd_data_q   <= rd_data_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_path_q <= pend_path_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
